// File: rtl/alu_rs.sv
// Reservation station for the single ALU: holds dispatched instructions until both
// operands are captured from the ALU/LSB broadcasts, then issues one ready entry per cycle.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  output logic                 full,
  input  logic                 disp_en,
  input  logic [6:0]           disp_opcode,
  input  logic [2:0]           disp_funct3,
  input  logic                 disp_funct7,
  input  logic                 disp_rs1_rdy,
  input  logic [31:0]          disp_rs1_val,
  input  logic [ROB_POS_W-1:0] disp_rs1_tag,
  input  logic                 disp_rs2_rdy,
  input  logic [31:0]          disp_rs2_val,
  input  logic [ROB_POS_W-1:0] disp_rs2_tag,
  input  logic [31:0]          disp_imm,
  input  logic [31:0]          disp_pc,
  input  logic [ROB_POS_W-1:0] disp_rob_pos,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   valid_q, valid_d, q1_q, q1_d, q2_q, q2_d, f7_q, f7_d;
  logic [6:0]           op_q  [RS_SIZE];
  logic [6:0]           op_d  [RS_SIZE];
  logic [2:0]           f3_q  [RS_SIZE];
  logic [2:0]           f3_d  [RS_SIZE];
  logic [31:0]          v1_q  [RS_SIZE];
  logic [31:0]          v1_d  [RS_SIZE];
  logic [31:0]          v2_q  [RS_SIZE];
  logic [31:0]          v2_d  [RS_SIZE];
  logic [31:0]          imm_q [RS_SIZE];
  logic [31:0]          imm_d [RS_SIZE];
  logic [31:0]          pc_q  [RS_SIZE];
  logic [31:0]          pc_d  [RS_SIZE];
  logic [ROB_POS_W-1:0] t1_q  [RS_SIZE];
  logic [ROB_POS_W-1:0] t1_d  [RS_SIZE];
  logic [ROB_POS_W-1:0] t2_q  [RS_SIZE];
  logic [ROB_POS_W-1:0] t2_d  [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_q [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_d [RS_SIZE];

  logic                 alu_en_q, alu_en_d, alu_f7_q, alu_f7_d;
  logic [6:0]           alu_op_q, alu_op_d;
  logic [2:0]           alu_f3_q, alu_f3_d;
  logic [31:0]          alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;
  logic [31:0]          alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  logic [ROB_POS_W-1:0] alu_rob_q, alu_rob_d;

  logic                 sel_vld, free_vld;
  logic [IDX_W-1:0]     sel_idx, free_idx;

  // Operand capture: an unready operand picks up a matching broadcast, ALU bus first.
  function automatic logic [32:0] capture(input logic rdy_in, input logic [31:0] val_in,
                                          input logic [ROB_POS_W-1:0] tag,
                                          input logic a_en, input logic [ROB_POS_W-1:0] a_tag,
                                          input logic [31:0] a_val,
                                          input logic l_en, input logic [ROB_POS_W-1:0] l_tag,
                                          input logic [31:0] l_val);
    logic [32:0] res;
    res = {rdy_in, val_in};
    if (!rdy_in) begin
      if (a_en && a_tag == tag)      res = {1'b1, a_val};
      else if (l_en && l_tag == tag) res = {1'b1, l_val};
    end
    return res;
  endfunction

  assign full = &valid_q;

  // Lowest-index ready entry and lowest-index free slot, both from registered state
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && q1_q[i] && q2_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;  q1_d = q1_q;  q2_d = q2_q;  f7_d = f7_q;
    op_d = op_q;  f3_d = f3_q;  v1_d = v1_q;  v2_d = v2_q;
    imm_d = imm_q;  pc_d = pc_q;  t1_d = t1_q;  t2_d = t2_q;  rob_d = rob_q;
    alu_en_d = alu_en_q;  alu_op_d = alu_op_q;  alu_f3_d = alu_f3_q;  alu_f7_d = alu_f7_q;
    alu_v1_d = alu_v1_q;  alu_v2_d = alu_v2_q;  alu_imm_d = alu_imm_q;
    alu_pc_d = alu_pc_q;  alu_rob_d = alu_rob_q;
    if (rdy) begin
      if (rollback) begin
        valid_d  = '0;
        alu_en_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid_q[i]) begin
            {q1_d[i], v1_d[i]} = capture(q1_q[i], v1_q[i], t1_q[i],
                                         alu_result, alu_result_rob_pos, alu_result_val,
                                         lsb_result, lsb_result_rob_pos, lsb_result_val);
            {q2_d[i], v2_d[i]} = capture(q2_q[i], v2_q[i], t2_q[i],
                                         alu_result, alu_result_rob_pos, alu_result_val,
                                         lsb_result, lsb_result_rob_pos, lsb_result_val);
          end
        end
        alu_en_d = sel_vld;
        if (sel_vld) begin
          valid_d[sel_idx] = 1'b0;
          alu_op_d  = op_q[sel_idx];
          alu_f3_d  = f3_q[sel_idx];
          alu_f7_d  = f7_q[sel_idx];
          alu_v1_d  = v1_q[sel_idx];
          alu_v2_d  = v2_q[sel_idx];
          alu_imm_d = imm_q[sel_idx];
          alu_pc_d  = pc_q[sel_idx];
          alu_rob_d = rob_q[sel_idx];
        end
        if (disp_en && free_vld) begin
          valid_d[free_idx] = 1'b1;
          op_d[free_idx]    = disp_opcode;
          f3_d[free_idx]    = disp_funct3;
          f7_d[free_idx]    = disp_funct7;
          t1_d[free_idx]    = disp_rs1_tag;
          t2_d[free_idx]    = disp_rs2_tag;
          imm_d[free_idx]   = disp_imm;
          pc_d[free_idx]    = disp_pc;
          rob_d[free_idx]   = disp_rob_pos;
          {q1_d[free_idx], v1_d[free_idx]} = capture(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
              alu_result, alu_result_rob_pos, alu_result_val,
              lsb_result, lsb_result_rob_pos, lsb_result_val);
          {q2_d[free_idx], v2_d[free_idx]} = capture(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag,
              alu_result, alu_result_rob_pos, alu_result_val,
              lsb_result, lsb_result_rob_pos, lsb_result_val);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;  q1_q <= '0;  q2_q <= '0;  f7_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;  f3_q[i] <= '0;  v1_q[i] <= '0;  v2_q[i]  <= '0;
        imm_q[i] <= '0;  pc_q[i] <= '0;  t1_q[i] <= '0;  t2_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      alu_en_q <= 1'b0;  alu_op_q <= '0;  alu_f3_q <= '0;  alu_f7_q <= 1'b0;
      alu_v1_q <= '0;  alu_v2_q <= '0;  alu_imm_q <= '0;  alu_pc_q <= '0;
      alu_rob_q <= '0;
    end else begin
      valid_q <= valid_d;  q1_q <= q1_d;  q2_q <= q2_d;  f7_q <= f7_d;
      op_q <= op_d;  f3_q <= f3_d;  v1_q <= v1_d;  v2_q <= v2_d;
      imm_q <= imm_d;  pc_q <= pc_d;  t1_q <= t1_d;  t2_q <= t2_d;  rob_q <= rob_d;
      alu_en_q <= alu_en_d;  alu_op_q <= alu_op_d;  alu_f3_q <= alu_f3_d;
      alu_f7_q <= alu_f7_d;  alu_v1_q <= alu_v1_d;  alu_v2_q <= alu_v2_d;
      alu_imm_q <= alu_imm_d;  alu_pc_q <= alu_pc_d;  alu_rob_q <= alu_rob_d;
    end
  end

  assign alu_en      = alu_en_q;
  assign alu_opcode  = alu_op_q;
  assign alu_funct3  = alu_f3_q;
  assign alu_funct7  = alu_f7_q;
  assign alu_val1    = alu_v1_q;
  assign alu_val2    = alu_v2_q;
  assign alu_imm     = alu_imm_q;
  assign alu_pc      = alu_pc_q;
  assign alu_rob_pos = alu_rob_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against an entry-list model.
module tb_alu_rs;
  localparam int N = 8;
  localparam int RW = 4;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic clk = 1'b0, rst, rdy, rollback, full;
  logic disp_en, disp_funct7, disp_rs1_rdy, disp_rs2_rdy;
  logic [6:0] disp_opcode;
  logic [2:0] disp_funct3;
  logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm, disp_pc;
  logic [RW-1:0] disp_rs1_tag, disp_rs2_tag, disp_rob_pos;
  logic alu_result, lsb_result;
  logic [RW-1:0] alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic alu_en, alu_funct7;
  logic [6:0] alu_opcode;
  logic [2:0] alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [RW-1:0] alu_rob_pos;

  int n_checks = 0;
  int n_fail = 0;

  alu_rs #(.RS_SIZE(N), .ROB_POS_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .full(full),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_funct3(disp_funct3),
    .disp_funct7(disp_funct7), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val),
    .disp_rs2_tag(disp_rs2_tag), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_rob_pos(disp_rob_pos), .alu_result(alu_result),
    .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1),
    .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; disp_en = 1'b0;
    disp_opcode = '0; disp_funct3 = '0; disp_funct7 = 1'b0;
    disp_rs1_rdy = 1'b0; disp_rs1_val = '0; disp_rs1_tag = '0;
    disp_rs2_rdy = 1'b0; disp_rs2_val = '0; disp_rs2_tag = '0;
    disp_imm = '0; disp_pc = '0; disp_rob_pos = '0;
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
  endtask

  task automatic set_disp(input logic [6:0] op, input logic r1, input logic [31:0] v1,
                          input logic [RW-1:0] t1, input logic r2, input logic [31:0] v2,
                          input logic [RW-1:0] t2, input logic [RW-1:0] rob);
    disp_en = 1'b1; disp_opcode = op; disp_funct3 = '0; disp_funct7 = 1'b0;
    disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
    disp_rob_pos = rob; disp_imm = 32'h1000 + 32'(rob); disp_pc = 32'h8000_0000 + 32'(rob) * 4;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({full, alu_en} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl: full/alu_en got %b want 00", {full, alu_en});
    end
    n_checks++;
    if ({alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos} !== '0) begin
      n_fail++; $display("FAIL reset_outs: alu_val1=%h alu_pc=%h rob=%0d want all 0",
                         alu_val1, alu_pc, alu_rob_pos);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({full, alu_en} !== 2'b00) begin
        n_fail++; $display("FAIL idle_%0d: full/alu_en got %b want 00", i, {full, alu_en});
      end
    end
  endtask

  task automatic test_add();
    set_disp(OP_ADD, 1'b1, 32'd5, '0, 1'b1, 32'd7, '0, 4'd3);
    tick();
    disp_en = 1'b0;
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL add_early: alu_en got %b want 0", alu_en); end
    tick();
    n_checks++;
    if ({alu_en, alu_opcode, alu_val1, alu_val2, alu_rob_pos, alu_imm} !==
        {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 32'h1003}) begin
      n_fail++; $display("FAIL add_issue: en=%b op=%b v1=%0d v2=%0d rob=%0d imm=%h want 1 %b 5 7 3 1003",
                         alu_en, alu_opcode, alu_val1, alu_val2, alu_rob_pos, alu_imm, OP_ADD);
    end
    tick();
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL add_after: alu_en got %b want 0", alu_en); end
    n_checks++;
    if (alu_val1 !== 32'd5) begin n_fail++; $display("FAIL add_hold: alu_val1 got %0d want 5", alu_val1); end
  endtask

  task automatic test_wakeup();
    set_disp(OP_ADDI, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, '0, 4'd4);
    tick();
    disp_en = 1'b0;
    tick();
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL wake_wait: alu_en got %b want 0", alu_en); end
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'h10;
    tick();
    lsb_result = 1'b0;
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL wake_capture: alu_en got %b want 0", alu_en); end
    tick();
    n_checks++;
    if ({alu_en, alu_val1, alu_rob_pos} !== {1'b1, 32'h10, 4'd4}) begin
      n_fail++; $display("FAIL wake_issue: en=%b v1=%h rob=%0d want 1 10 4", alu_en, alu_val1, alu_rob_pos);
    end
    tick();
  endtask

  task automatic test_bypass();
    set_disp(OP_ADD, 1'b0, 32'd0, 4'd6, 1'b1, 32'd9, '0, 4'd5);
    alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'hAB;
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd6; lsb_result_val = 32'hCD;
    tick();
    disp_en = 1'b0; alu_result = 1'b0; lsb_result = 1'b0;
    tick();
    n_checks++;
    if ({alu_en, alu_val1, alu_val2} !== {1'b1, 32'hAB, 32'd9}) begin
      n_fail++; $display("FAIL bypass: en=%b v1=%h v2=%0d want 1 ab 9", alu_en, alu_val1, alu_val2);
    end
    tick();
  endtask

  task automatic test_capacity();
    for (int i = 0; i < N; i++) begin
      set_disp(OP_ADD, 1'b0, 32'd0, RW'(8 + i), 1'b1, 32'd0, '0, RW'(i));
      tick();
      if (i == N - 2) begin
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL cap_not_full: full got %b want 0", full); end
      end
    end
    n_checks++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL cap_full: full got %b want 1", full); end
    set_disp(OP_ADD, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0, 4'd15);
    tick();
    disp_en = 1'b0;
    tick();
    n_checks++;
    if ({full, alu_en} !== 2'b10) begin
      n_fail++; $display("FAIL cap_ignore: full/alu_en got %b want 10", {full, alu_en});
    end
    alu_result = 1'b1; alu_result_rob_pos = 4'd12; alu_result_val = 32'h44;
    tick();
    alu_result = 1'b0;
    n_checks++;
    if ({full, alu_en} !== 2'b10) begin
      n_fail++; $display("FAIL cap_wake: full/alu_en got %b want 10", {full, alu_en});
    end
    tick();
    n_checks++;
    if ({full, alu_en, alu_rob_pos, alu_val1} !== {1'b0, 1'b1, 4'd4, 32'h44}) begin
      n_fail++; $display("FAIL cap_issue: full=%b en=%b rob=%0d v1=%h want 0 1 4 44",
                         full, alu_en, alu_rob_pos, alu_val1);
    end
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 5; i++) begin
      set_disp(OP_ADD, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, '0, RW'(i));
      tick();
    end
    set_disp(OP_ADD, 1'b1, 32'd3, '0, 1'b1, 32'd4, '0, 4'd7);
    tick();
    disp_en = 1'b0;
    tick();
    n_checks++;
    if ({full, alu_en, alu_rob_pos} !== {1'b0, 1'b1, 4'd7}) begin
      n_fail++; $display("FAIL rb_pre: full=%b en=%b rob=%0d want 0 1 7", full, alu_en, alu_rob_pos);
    end
    rollback = 1'b1;
    set_disp(OP_ADD, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0, 4'd8);
    tick();
    rollback = 1'b0; disp_en = 1'b0;
    n_checks++;
    if ({full, alu_en} !== 2'b00) begin
      n_fail++; $display("FAIL rb_flush: full/alu_en got %b want 00", {full, alu_en});
    end
    alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
    tick();
    alu_result = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (alu_en !== 1'b0) begin n_fail++; $display("FAIL rb_quiet_%0d: alu_en got %b want 0", i, alu_en); end
    end
  endtask

  task automatic test_freeze();
    set_disp(OP_ADD, 1'b1, 32'd2, '0, 1'b1, 32'd3, '0, 4'd1);
    tick();
    disp_en = 1'b0;
    tick();
    rdy = 1'b0;
    tick(); tick();
    n_checks++;
    if ({alu_en, alu_rob_pos} !== {1'b1, 4'd1}) begin
      n_fail++; $display("FAIL frz_hold: en=%b rob=%0d want 1 1", alu_en, alu_rob_pos);
    end
    rdy = 1'b1;
    tick();
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL frz_release: alu_en got %b want 0", alu_en); end
    rdy = 1'b0;
    set_disp(OP_ADD, 1'b1, 32'd2, '0, 1'b1, 32'd3, '0, 4'd2);
    tick(); tick();
    disp_en = 1'b0; rdy = 1'b1;
    tick(); tick();
    n_checks++;
    if ({full, alu_en} !== 2'b00) begin
      n_fail++; $display("FAIL frz_disp: full/alu_en got %b want 00", {full, alu_en});
    end
    set_disp(OP_ADD, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, '0, 4'd5);
    tick();
    disp_en = 1'b0; rdy = 1'b0;
    alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h77;
    tick();
    alu_result = 1'b0; rdy = 1'b1;
    tick(); tick();
    n_checks++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL frz_bcast: alu_en got %b want 0", alu_en); end
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
  endtask

  typedef struct {
    logic v; logic [6:0] op; logic [2:0] f3; logic f7;
    logic r1; logic [31:0] v1; logic [RW-1:0] t1;
    logic r2; logic [31:0] v2; logic [RW-1:0] t2;
    logic [31:0] imm; logic [31:0] pc; logic [RW-1:0] rob;
  } ent_t;

  ent_t m [N];
  ent_t exp_out;
  logic exp_en;

  function automatic logic [32:0] resolve(input logic r, input logic [31:0] v, input logic [RW-1:0] t);
    if (r) return {1'b1, v};
    if (alu_result && alu_result_rob_pos == t) return {1'b1, alu_result_val};
    if (lsb_result && lsb_result_rob_pos == t) return {1'b1, lsb_result_val};
    return {1'b0, v};
  endfunction

  task automatic model_edge();
    int iss, slot;
    ent_t nd;
    if (!rdy) return;
    if (rollback) begin
      for (int i = 0; i < N; i++) m[i].v = 1'b0;
      exp_en = 1'b0;
      return;
    end
    iss = -1; slot = -1;
    for (int i = 0; i < N; i++) begin
      if (iss < 0 && m[i].v && m[i].r1 && m[i].r2) iss = i;
      if (slot < 0 && !m[i].v) slot = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].v) begin
        {m[i].r1, m[i].v1} = resolve(m[i].r1, m[i].v1, m[i].t1);
        {m[i].r2, m[i].v2} = resolve(m[i].r2, m[i].v2, m[i].t2);
      end
    end
    exp_en = (iss >= 0);
    if (iss >= 0) begin
      exp_out = m[iss];
      m[iss].v = 1'b0;
    end
    if (disp_en && slot >= 0) begin
      nd.v = 1'b1; nd.op = disp_opcode; nd.f3 = disp_funct3; nd.f7 = disp_funct7;
      nd.t1 = disp_rs1_tag; nd.t2 = disp_rs2_tag;
      {nd.r1, nd.v1} = resolve(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag);
      {nd.r2, nd.v2} = resolve(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag);
      nd.imm = disp_imm; nd.pc = disp_pc; nd.rob = disp_rob_pos;
      m[slot] = nd;
    end
  endtask

  task automatic test_random();
    logic exp_full;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    exp_out = '{default: '0};
    exp_en = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      disp_en = $urandom_range(0, 1);
      disp_opcode = 7'($urandom); disp_funct3 = 3'($urandom); disp_funct7 = 1'($urandom);
      disp_rs1_rdy = ($urandom_range(0, 2) != 0); disp_rs1_val = $urandom;
      disp_rs1_tag = RW'($urandom);
      disp_rs2_rdy = ($urandom_range(0, 2) != 0); disp_rs2_val = $urandom;
      disp_rs2_tag = RW'($urandom);
      disp_imm = $urandom; disp_pc = $urandom; disp_rob_pos = RW'($urandom);
      alu_result = ($urandom_range(0, 2) == 0); alu_result_rob_pos = RW'($urandom);
      alu_result_val = $urandom;
      lsb_result = ($urandom_range(0, 2) == 0); lsb_result_rob_pos = RW'($urandom);
      lsb_result_val = $urandom;
      model_edge();
      tick();
      exp_full = 1'b1;
      for (int i = 0; i < N; i++) if (!m[i].v) exp_full = 1'b0;
      n_checks++;
      if ({full, alu_en} !== {exp_full, exp_en}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc %0d: full/alu_en got %b want %b", c,
                           {full, alu_en}, {exp_full, exp_en});
      end
      n_checks++;
      if ({alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos} !==
          {exp_out.op, exp_out.f3, exp_out.f7, exp_out.v1, exp_out.v2, exp_out.imm, exp_out.pc,
           exp_out.rob}) begin
        n_fail++; $display("FAIL rnd_data cyc %0d: v1=%h v2=%h rob=%0d pc=%h want v1=%h v2=%h rob=%0d pc=%h",
                           c, alu_val1, alu_val2, alu_rob_pos, alu_pc,
                           exp_out.v1, exp_out.v2, exp_out.rob, exp_out.pc);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_bypass();
    test_capacity();
    test_rollback();
    test_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the single ALU in the out-of-order core. It accepts decoded ALU-class instructions from dispatch and holds them until both operands are known. Operands are captured from the two result broadcasts (ALU and LSB). Each cycle it issues at most one ready entry to the ALU through a registered issue port, and it flushes on rollback.

## Interface
- RS_SIZE, 8: number of entries; power of two, minimum 2.
- ROB_POS_W, 4: width of ROB position tags.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when 0 all state and outputs freeze.
- rollback  in  1  mispredict flush.
- full  out  1  all entries valid; combinational from the valid bits.
- disp_en  in  1  dispatch strobe.
- disp_opcode  in  7  instruction opcode.
- disp_funct3  in  3  instruction funct3.
- disp_funct7  in  1  instruction funct7 bit.
- disp_rs1_rdy  in  1  rs1 value is valid.
- disp_rs1_val  in  32  rs1 value.
- disp_rs1_tag  in  ROB_POS_W  producer ROB position for rs1.
- disp_rs2_rdy  in  1  rs2 value is valid.
- disp_rs2_val  in  32  rs2 value.
- disp_rs2_tag  in  ROB_POS_W  producer ROB position for rs2.
- disp_imm  in  32  immediate.
- disp_pc  in  32  instruction address.
- disp_rob_pos  in  ROB_POS_W  destination ROB position.
- alu_result  in  1  ALU broadcast valid.
- alu_result_rob_pos  in  ROB_POS_W  ALU broadcast tag.
- alu_result_val  in  32  ALU broadcast value.
- lsb_result  in  1  LSB broadcast valid.
- lsb_result_rob_pos  in  ROB_POS_W  LSB broadcast tag.
- lsb_result_val  in  32  LSB broadcast value.
- alu_en  out  1  issue strobe; registered.
- alu_opcode  out  7  issued opcode; registered.
- alu_funct3  out  3  issued funct3; registered.
- alu_funct7  out  1  issued funct7; registered.
- alu_val1  out  32  issued rs1 value; registered.
- alu_val2  out  32  issued rs2 value; registered.
- alu_imm  out  32  issued immediate; registered.
- alu_pc  out  32  issued pc; registered.
- alu_rob_pos  out  ROB_POS_W  issued ROB position; registered.

## Operation
- Entry fields: valid, opcode, funct3, funct7, q1_rdy, v1, t1, q2_rdy, v2, t2, imm, pc, rob_pos.
- Unused operands are handled upstream. Dispatch sets rsX_rdy=1 for operands an opcode does not use: rs2 for ARITHI/JALR, both for LUI/AUIPC/JAL.
- Allocation:
  - On disp_en && !full, the lowest-index invalid entry is written and becomes valid.
  - disp_en while full is ignored with no state change; upstream must not do this.
- Wake-up:
  - For every valid entry with qX_rdy=0, a broadcast whose tag equals tX sets qX_rdy=1 and vX=broadcast value.
  - The ALU and LSB buses are checked independently in the same cycle.
- Dispatch bypass:
  - If an operand arrives with rsX_rdy=0 and its tag matches a broadcast in the same cycle, it is stored already ready with the broadcast value.
  - On a tag match on both buses, the ALU value wins.
- Select:
  - An entry is ready when valid && q1_rdy && q2_rdy.
  - The lowest-index ready entry issues: its fields load into the alu_* registers, alu_en<=1, and the entry is invalidated in the same edge.
  - With no ready entry, alu_en<=0 and the other alu_* outputs hold.
- An entry written this cycle is not eligible for select until the next cycle.
- A freed entry can be reallocated at the following edge, not the same edge.
- rst or rollback:
  - All valid bits clear and alu_en<=0.
  - The data registers, alu_* outputs and entry fields reset to 0 on rst only.
  - rollback takes priority over a simultaneous dispatch, which is dropped.
- rdy=0 blocks every update, including broadcast capture. Broadcasts arriving while rdy=0 are not seen.

## Timing
- After reset: full=0, alu_en=0, all alu_* outputs 0.
- Dispatch with both operands ready at edge t: entry valid after t; alu_en=1 after edge t+1.
- Broadcast during cycle t wakes a waiting entry at edge t; alu_en=1 after edge t+1.
- Issue throughput is 1 per cycle. alu_en stays high on consecutive cycles while ready entries exist.
- full asserts the cycle after the RS_SIZE-th allocation. It deasserts the cycle after an issue, provided no allocation happens in that same edge.

## Test plan
- Reset, then idle: full=0 and alu_en=0 for 10 cycles.
- Dispatch ADD (opcode 0110011), rs1=5, rs2=7, both ready, rob_pos=3: two edges later alu_en=1, alu_val1=5, alu_val2=7, alu_rob_pos=3; the next cycle alu_en=0.
- Dependency wake-up:
  - Dispatch ADDI with rs1 tag 2 not ready; alu_en stays 0.
  - Pulse lsb_result with rob_pos=2, val=0x10.
  - Next cycle alu_en=1 with alu_val1=0x10.
- Same-cycle bypass: dispatch with rs1 tag 6 not ready while alu_result=1, rob_pos=6, val=0xAB → issues with alu_val1=0xAB, no stall.
- Capacity:
  - Dispatch 8 non-ready entries → full=1; a 9th dispatch is ignored.
  - Broadcast waking entry 4 → entry 4 issues and full drops.
- Rollback: with 5 entries valid and alu_en=1, assert rollback → next cycle alu_en=0, full=0, and no further issues even if matching broadcasts arrive.
